// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: datapath width,
// NOP encoding and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request presented to instruction memory
    S_WAIT  = 2'd1,  // request accepted, awaiting response
    S_DROP  = 2'd2,  // request accepted, response will be discarded
    S_HOLD  = 2'd3   // response parked in hold buffer until decode frees up
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports: clk, rst (sync active-high); load/flush/stall controls;
// load_pc/load_instr new entry; if_id_* registered outputs.
// Priority: flush > load > stall (hold) > bubble (valid cleared).
module if_id_reg #(
  parameter int unsigned XLEN = fetch_stage_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            stall,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr
);
  import fetch_stage_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [31:0]     instr_q, instr_d;

  // Next-entry selection
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    instr_d    = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      pc_d       = load_pc;
      pc_plus4_d = load_pc + PC_STEP;
      instr_d    = load_instr;
    end else if (!stall) begin
      // decode consumed the entry and nothing replaces it
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= NOP_INSTR;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instr_q    <= instr_d;
    end
  end

  assign if_id_valid    = valid_q;
  assign if_id_pc       = pc_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_instr    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// redirect handling, one-entry hold buffer, IF/ID register.
// Ports: clk, rst (sync active-high); redirect_valid/target from branch unit;
// stall from decode; imem_req_* request channel; imem_resp_* response
// channel; if_id_* pipeline register outputs.
module fetch_stage #(
  parameter int unsigned            XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0]        RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr
);
  import fetch_stage_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]     hold_instr_q, hold_instr_d;

  logic            ifid_load;
  logic            ifid_flush;
  logic [XLEN-1:0] ifid_load_pc;
  logic [31:0]     ifid_load_instr;
  logic            accept_c;

  // Request is decoded straight from state so it is visible in the cycle
  // the FSM enters FETCH; reset masks it.
  assign imem_req_valid = !rst && (state_q == S_FETCH);
  assign imem_req_addr  = pc_q;
  assign accept_c       = imem_req_valid && imem_req_ready;

  // Next-state and IF/ID control
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_pc_d        = req_pc_q;
    hold_pc_d       = hold_pc_q;
    hold_instr_d    = hold_instr_q;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    ifid_load_pc    = req_pc_q;
    ifid_load_instr = imem_resp_data;

    unique case (state_q)
      S_FETCH: begin
        if (accept_c) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (!stall || !if_id_valid) begin
            ifid_load = 1'b1;
            state_d   = S_FETCH;
          end else begin
            hold_pc_d    = req_pc_q;
            hold_instr_d = imem_resp_data;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          ifid_load       = 1'b1;
          ifid_load_pc    = hold_pc_q;
          ifid_load_instr = hold_instr_q;
          state_d         = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect overrides everything above. Any request still in flight must
    // have its response swallowed; a response arriving this very cycle
    // retires it, so no drop is pending afterwards.
    if (redirect_valid) begin
      pc_d         = redirect_target & ALIGN_MASK;
      ifid_load    = 1'b0;
      ifid_flush   = 1'b1;
      hold_pc_d    = '0;
      hold_instr_d = '0;
      unique case (state_q)
        S_FETCH: state_d = accept_c ? S_DROP : S_FETCH;
        S_WAIT:  state_d = imem_resp_valid ? S_FETCH : S_DROP;
        S_DROP:  state_d = imem_resp_valid ? S_FETCH : S_DROP;
        S_HOLD:  state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC & ALIGN_MASK;
      req_pc_q     <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  if_id_reg #(
    .XLEN (XLEN)
  ) u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (ifid_load),
    .flush          (ifid_flush),
    .stall          (stall),
    .load_pc        (ifid_load_pc),
    .load_instr     (ifid_load_instr),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr)
  );

endmodule
